// File: rtl/red_seq_pkg.sv
// Shared types and constants for the RED (byte-sum reduction) sequencer.
package red_pkg;

    localparam int NIBS   = 3;   // nibbles per 12-bit internal sum
    localparam int SUM_W  = 12;  // internal sum width
    localparam int LANE_W = 8;   // byte lane width

    // Index of the final nibble of each 12-bit addition
    localparam logic [1:0] NIB_LAST = 2'(NIBS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AB   = 3'd1,
        CD   = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Sign-extend one signed byte lane to the internal sum width
    function automatic logic [SUM_W-1:0] sext_lane(input logic [LANE_W-1:0] v);
        return {{(SUM_W - LANE_W){v[LANE_W-1]}}, v};
    endfunction

endpackage

// File: rtl/red_seq_cla.sv
// 4-bit carry-lookahead adder slice shared by the RED sequencer.
module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pg
            assign p[gi] = A[gi] ^ B[gi];
            assign g[gi] = A[gi] & B[gi];
        end
    endgenerate

    // Flat lookahead carry equations, every carry derived from Cin directly
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign S    = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/red_seq.sv
// RED sequencer: signed sum of the four bytes of rs/rt, one nibble per
// cycle through a single shared CLA_4bit (a+b, then c+d, then the final sum).
module red_seq
    import red_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] rs,
    input  logic [15:0] rt,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd
);

    state_e           state_q, state_d;
    logic [1:0]       nib_q;
    logic             carry_q;
    logic [SUM_W-1:0] a_q, b_q, c_q, d_q;
    logic [SUM_W-1:0] sab_q, scd_q;
    logic [7:0]       sum_lo_q;   // low two nibbles of the final sum
    logic [15:0]      rd_q;

    logic [3:0]       op_a, op_b;
    logic [3:0]       cla_s;
    logic             cla_cout;
    logic [3:0]       nib_base;
    logic             nib_last;
    logic             accept;

    assign nib_base = {nib_q, 2'b00};
    assign nib_last = (nib_q == NIB_LAST);
    assign accept   = (state_q == IDLE) && start && !flush;

    CLA_4bit u_cla (
        .A    (op_a),
        .B    (op_b),
        .Cin  (carry_q),
        .S    (cla_s),
        .Cout (cla_cout)
    );

    // Select the operand nibbles for the adder from the current phase and nibble
    always_comb begin
        op_a = 4'h0;
        op_b = 4'h0;
        case (state_q)
            AB: begin
                op_a = a_q[nib_base +: 4];
                op_b = b_q[nib_base +: 4];
            end
            CD: begin
                op_a = c_q[nib_base +: 4];
                op_b = d_q[nib_base +: 4];
            end
            FIN: begin
                op_a = sab_q[nib_base +: 4];
                op_b = scd_q[nib_base +: 4];
            end
            default: begin
                op_a = 4'h0;
                op_b = 4'h0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush returns to IDLE from any busy phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = AB;
            AB:   if (flush) state_d = IDLE; else if (nib_last) state_d = CD;
            CD:   if (flush) state_d = IDLE; else if (nib_last) state_d = FIN;
            FIN:  if (flush) state_d = IDLE; else if (nib_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath: operand capture, nibble counter, ripple carry between nibbles, partial sums and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_q    <= 2'd0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            sab_q    <= '0;
            scd_q    <= '0;
            sum_lo_q <= '0;
            rd_q     <= 16'h0000;
        end else if (state_q == IDLE) begin
            nib_q   <= 2'd0;
            carry_q <= 1'b0;
            if (accept) begin
                a_q <= sext_lane(rs[15:8]);
                b_q <= sext_lane(rs[7:0]);
                c_q <= sext_lane(rt[15:8]);
                d_q <= sext_lane(rt[7:0]);
            end
        end else if (flush || state_q == DONE) begin
            nib_q   <= 2'd0;
            carry_q <= 1'b0;
        end else begin
            // Carry-out of the last nibble is dropped; each addition starts with Cin=0
            nib_q   <= nib_last ? 2'd0 : nib_q + 2'd1;
            carry_q <= nib_last ? 1'b0 : cla_cout;
            case (state_q)
                AB: sab_q[nib_base +: 4] <= cla_s;
                CD: scd_q[nib_base +: 4] <= cla_s;
                FIN: begin
                    if (nib_last)
                        rd_q <= {{4{cla_s[3]}}, cla_s, sum_lo_q};
                    else
                        sum_lo_q[{nib_q[0], 2'b00} +: 4] <= cla_s;
                end
                default: ;
            endcase
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_red_seq.sv
// Self-checking bench for red_seq: directed corner cases plus random operands
// compared with an arithmetic byte-sum reference.
module tb_red_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [15:0] rs;
    logic [15:0] rt;
    logic        busy;
    logic        done;
    logic [15:0] rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    red_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .rd    (rd)
    );

    // Reference: plain signed arithmetic on the four bytes
    function automatic logic [15:0] ref_red(input logic [15:0] x, input logic [15:0] y);
        logic signed [7:0] ba, bb, bc, bd;
        int s;
        ba = x[15:8];
        bb = x[7:0];
        bc = y[15:8];
        bd = y[7:0];
        s  = int'(ba) + int'(bb) + int'(bc) + int'(bd);
        return 16'(s);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete RED; optionally disturbs inputs and re-pulses start mid-operation
    task automatic run_red(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input bit disturb);
        logic [15:0] exp;
        int n;
        exp = ref_red(a, b);
        @(posedge clk); #1;
        rs = a; rt = b; start = 1'b1;
        @(posedge clk); #1;                 // accept edge E0 just passed
        start = 1'b0;
        rs = 16'($urandom); rt = 16'($urandom);
        @(negedge clk);
        check({tag, "_busy_rise"}, {15'd0, busy}, 16'd1);
        n = 0;
        while (n < 20 && done !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (disturb && n == 3) begin
                rs = 16'($urandom); rt = 16'($urandom); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_latency"}, 16'(n), 16'd9);
        check({tag, "_rd"}, rd, exp);
        @(negedge clk);
        check({tag, "_done_single"}, {15'd0, done}, 16'd0);
        check({tag, "_idle"}, {15'd0, busy}, 16'd0);
        $display("RED %s rs=%h rt=%h rd=%h exp=%h edges=%0d", tag, a, b, rd, exp, n);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; flush = 1'b0; rs = 16'h0; rt = 16'h0;
        #12;
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_rd", rd, 16'h0000);
        @(negedge clk); rst = 1'b0;

        // Directed corners
        run_red("basic", 16'h0102, 16'h0304, 1'b0);
        run_red("min",   16'h8080, 16'h8080, 1'b0);
        run_red("max",   16'h7F7F, 16'h7F7F, 1'b0);
        run_red("neg1_ignore_start", 16'hFF01, 16'h00FF, 1'b1);

        // Flush mid-operation: no done, rd held
        run_red("pre_flush", 16'h0102, 16'h0304, 1'b0);
        @(posedge clk); #1;
        rs = 16'h7F7F; rt = 16'h7F7F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_low", {15'd0, busy}, 16'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("flush_no_done", 16'(dones), 16'd0);
        check("flush_rd_held", rd, 16'h000A);
        $display("RED flush rd=%h dones=%0d", rd, dones);

        // Flush together with start in IDLE: request dropped
        @(posedge clk); #1;
        rs = 16'h7F7F; rt = 16'h7F7F; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle_busy", {15'd0, busy}, 16'd0);
        repeat (11) @(negedge clk);
        check("flush_start_idle_rd", rd, 16'h000A);
        $display("RED flush_with_start busy=%b rd=%h", busy, rd);

        // Asynchronous reset mid-operation
        @(posedge clk); #1;
        rs = 16'h0102; rt = 16'h0304; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {15'd0, busy}, 16'd0);
        check("async_rst_done", {15'd0, done}, 16'd0);
        check("async_rst_rd", rd, 16'h0000);
        $display("RED async_reset busy=%b done=%b rd=%h", busy, done, rd);
        @(negedge clk); rst = 1'b0;
        run_red("after_rst", 16'h0102, 16'h0304, 1'b0);

        // Random operands
        for (int i = 0; i < 16; i++) begin
            run_red("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/red_seq.md
Name: red_seq

Overview:
Multi-cycle sequencer for the reduction (RED) operation. It computes the signed sum of the four bytes in two 16-bit source registers using one shared CLA_4bit slice, one nibble per cycle. It sits beside the ALU for area-reduced builds and presents a start/busy/done handshake to the execute-stage stall logic.

Parameters:
None. All widths are fixed by the ISA: 16-bit registers, 8-bit lanes, 12-bit internal sums of 3 nibbles each.

Ports:
clk    input   1   system clock; all state changes on rising edge
rst    input   1   asynchronous, active-high reset
start  input   1   request a new RED; sampled only in IDLE
flush  input   1   synchronous abort of an in-flight RED
rs     input   16  source register A: bytes a=rs[15:8], b=rs[7:0]
rt     input   16  source register B: bytes c=rt[15:8], d=rt[7:0]
busy   output  1   high whenever state != IDLE
done   output  1   one-cycle pulse; rd is valid and updated
rd     output  16  registered result; holds value until next completion

Behaviour:
- Arithmetic:
  - rd = sext16(sext(a)+sext(b)+sext(c)+sext(d)); each byte is a signed 8-bit value.
  - Result range is -512..508, so there is no overflow or saturation.
- Internal width rules:
  - On accept, each byte is sign-extended to 12 bits and latched.
  - Every addition is 12-bit, done as 3 nibble cycles (nib 0,1,2) through one CLA_4bit.
  - Carry-in is 0 at nib 0; otherwise it is the registered carry-out from the previous nibble.
  - Carry-out of nib 2 is discarded.
  - rd = {4{sum[11]}, sum[11:0]}.
- States: IDLE, AB, CD, FIN, DONE. A 2-bit nibble counter nib runs 0..2.
  - IDLE: if start, latch the four sign-extended bytes, clear carry, go to AB with nib=0. Otherwise stay.
  - AB: sab[nib] = a+b nibble. At nib=2 go to CD, nib=0.
  - CD: scd[nib] = c+d nibble. At nib=2 go to FIN, nib=0.
  - FIN: sum[nib] = sab+scd nibble. At nib=2, write rd from the completed sum and go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency:
  - Start is accepted at edge E0.
  - Compute edges are E1..E9; rd updates at E9.
  - done is high in the cycle after E9, and the state is IDLE after E10.
  - Back-to-back requests: the next start is accepted no earlier than the IDLE cycle after DONE, i.e. one request per 11 cycles.
- start while busy (including DONE): ignored. Latched operands are unchanged and there is no queueing.
- Operands are captured at accept. rs/rt may change freely afterwards.
- flush:
  - In any state other than IDLE, the next state is IDLE and nib/carry are cleared.
  - rd keeps its previous value and no done pulse is produced.
  - flush in DONE suppresses nothing: done is already asserted that cycle, and the next state is IDLE as normal.
  - flush together with start in IDLE: flush wins and the request is not accepted.
- rst (asynchronous, any time, including mid-operation): state=IDLE, nib=0, carry=0, all operand/partial registers=0, rd=16'h0000, done=0, busy=0.
- Outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

Decomposition:
- Package red_pkg:
  - state enum {IDLE, AB, CD, FIN, DONE}
  - localparam NIBS=3
  - localparam SUM_W=12
  - localparam LANE_W=8
- Sub-module: exactly one instance of the existing CLA_4bit (ports A, B, Cin, S, Cout).
  - Operand muxing is selected by state and nib.
  - The carry register and result/partial registers live in red_seq.

Test Plan:
- rs=16'h0102, rt=16'h0304, start pulsed one cycle from IDLE -> busy rises next cycle; done pulses in the cycle after the 9th compute edge; rd=16'h000A.
- rs=16'h8080, rt=16'h8080 -> rd=16'hFE00 (-512), covering the minimum and sign extension.
- rs=16'h7F7F, rt=16'h7F7F -> rd=16'h01FC (+508), covering the maximum and inter-nibble carries.
- rs=16'hFF01, rt=16'h00FF -> rd=16'hFFFF (-1). Then, during the op, change rs/rt and pulse start at cycle 4 -> ignored; result still 16'hFFFF; single done pulse.
- Complete a RED with rd=16'h000A. Start another and assert flush at its 5th cycle -> busy low next cycle, no done, rd stays 16'h000A. Also drive flush and start together in IDLE -> not accepted.
- Start a RED and assert rst asynchronously mid-cycle at its 4th cycle -> busy=0, done=0, rd=16'h0000 immediately. After deassert, a new start with rs=16'h0102, rt=16'h0304 completes normally with rd=16'h000A.
